// File: rtl/sdram_wr_fifo_ctrl_if.sv
// Byte-stream and SDRAM write-port signal bundle for sdram_wr_fifo_ctrl.
// master = the controller itself, slave = the byte source / SDRAM controller side.
interface sdram_wr_fifo_ctrl_if;
  logic        init_end;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        flush;
  logic        sdram_wr_ack;
  logic        sdram_wr_req;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  wr_burst_len;
  logic [15:0] sdram_data_in;
  logic [6:0]  fifo_count;
  logic        overflow;
  logic        wr_done;

  modport master (
    input  init_end,
    input  byte_valid,
    input  byte_data,
    input  flush,
    input  sdram_wr_ack,
    output sdram_wr_req,
    output sdram_wr_addr,
    output wr_burst_len,
    output sdram_data_in,
    output fifo_count,
    output overflow,
    output wr_done
  );

  modport slave (
    output init_end,
    output byte_valid,
    output byte_data,
    output flush,
    output sdram_wr_ack,
    input  sdram_wr_req,
    input  sdram_wr_addr,
    input  wr_burst_len,
    input  sdram_data_in,
    input  fifo_count,
    input  overflow,
    input  wr_done
  );
endinterface

// File: rtl/sdram_wr_fifo_ctrl.sv
// Packs a UART byte stream into 16-bit words, buffers them in a 64-deep
// show-ahead FIFO and drains them to SDRAM as fixed or flush-sized write bursts.
module sdram_wr_fifo_ctrl #(
  parameter int unsigned BURST_LEN = 10,
  parameter logic [23:0] ADDR_BASE = 24'h000000,
  parameter logic [23:0] ADDR_MAX  = 24'h0003FF
) (
  input  logic                        clk_100m,
  input  logic                        rst_n,
  sdram_wr_fifo_ctrl_if.master        bus_io
);

  localparam logic [6:0]  FIFO_FULL  = 7'd64;
  localparam logic [6:0]  BURST_CNT  = 7'(BURST_LEN);
  localparam logic [9:0]  BURST_LEN10 = 10'(BURST_LEN);
  localparam logic [24:0] BURST_SPAN = 25'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        odd_q, odd_d;
  logic        push_q, push_d;
  logic [15:0] push_word_q, push_word_d;
  logic        flush_pending_q, flush_pending_d;
  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;
  logic [6:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic [23:0] addr_q, addr_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  ack_cnt_q, ack_cnt_d;

  logic [15:0] mem [0:63];

  logic        fifo_full, fifo_empty;
  logic        do_push, do_pop, ack_active;
  logic        pad_now, flush_quiet, flush_clr;
  logic [24:0] next_addr, next_end;

  // ---------------------------------------------------------------- packer
  // A held odd byte is padded only when no new byte arrives that cycle, so a
  // flush coinciding with the completing byte never produces a spurious pad.
  assign pad_now = odd_q && !bus_io.byte_valid && (bus_io.flush || flush_pending_q);

  always_comb begin
    hi_byte_d   = hi_byte_q;
    odd_d       = odd_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    if (bus_io.byte_valid) begin
      if (odd_q) begin
        push_d      = 1'b1;
        push_word_d = {hi_byte_q, bus_io.byte_data};
        odd_d       = 1'b0;
      end else begin
        hi_byte_d = bus_io.byte_data;
        odd_d     = 1'b1;
      end
    end else if (pad_now) begin
      push_d      = 1'b1;
      push_word_d = {hi_byte_q, 8'h00};
      odd_d       = 1'b0;
    end
  end

  // ---------------------------------------------------------------- FIFO
  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == 7'd0);
  assign ack_active = ((state_q == REQ) || (state_q == WRITE)) && bus_io.sdram_wr_ack;
  assign do_push    = push_q && !fifo_full;
  assign do_pop     = ack_active && !fifo_empty;

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + 6'd1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 6'd1 : rd_ptr_q;
    overflow_d = overflow_q || (push_q && fifo_full);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_word_q;
    end
  end

  // ---------------------------------------------------------------- burst FSM
  // A flush-sized burst waits until the pad word has landed in the FIFO.
  assign flush_quiet = flush_pending_q && !odd_q && !push_q;
  assign next_addr   = {1'b0, addr_q} + {15'd0, len_q};
  assign next_end    = next_addr + BURST_SPAN;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    ack_cnt_d = ack_cnt_q;
    flush_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_io.init_end && (count_q >= BURST_CNT)) begin
          state_d   = REQ;
          len_d     = BURST_LEN10;
          ack_cnt_d = 10'd0;
        end else if (flush_quiet && fifo_empty) begin
          flush_clr = 1'b1;
        end else if (bus_io.init_end && flush_quiet) begin
          state_d   = REQ;
          len_d     = {3'b000, count_q};
          ack_cnt_d = 10'd0;
          flush_clr = 1'b1;
        end
      end
      REQ, WRITE: begin
        if (bus_io.sdram_wr_ack) begin
          ack_cnt_d = ack_cnt_q + 10'd1;
          state_d   = ((ack_cnt_q + 10'd1) == len_q) ? DONE : WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = (next_end > {1'b0, ADDR_MAX}) ? ADDR_BASE : next_addr[23:0];
      end
      default: state_d = IDLE;
    endcase
  end

  // A new flush always wins over the clear so it is never lost.
  assign flush_pending_d = bus_io.flush ? 1'b1 : (flush_clr ? 1'b0 : flush_pending_q);

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      hi_byte_q       <= 8'h00;
      odd_q           <= 1'b0;
      push_q          <= 1'b0;
      push_word_q     <= 16'h0000;
      flush_pending_q <= 1'b0;
      wr_ptr_q        <= 6'd0;
      rd_ptr_q        <= 6'd0;
      count_q         <= 7'd0;
      overflow_q      <= 1'b0;
      addr_q          <= ADDR_BASE;
      len_q           <= 10'd0;
      ack_cnt_q       <= 10'd0;
    end else begin
      state_q         <= state_d;
      hi_byte_q       <= hi_byte_d;
      odd_q           <= odd_d;
      push_q          <= push_d;
      push_word_q     <= push_word_d;
      flush_pending_q <= flush_pending_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      overflow_q      <= overflow_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      ack_cnt_q       <= ack_cnt_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus_io.sdram_wr_req  = (state_q == REQ) || (state_q == WRITE);
  assign bus_io.wr_done       = (state_q == DONE);
  assign bus_io.sdram_wr_addr = addr_q;
  assign bus_io.wr_burst_len  = len_q;
  assign bus_io.sdram_data_in = fifo_empty ? 16'h0000 : mem[rd_ptr_q];
  assign bus_io.fifo_count    = count_q;
  assign bus_io.overflow      = overflow_q;

endmodule

// File: tb/tb_sdram_wr_fifo_ctrl.sv
// Scoreboard bench: stimulus queues expected bursts/words, a monitor checks
// every burst start and every acknowledged word as the DUT presents it.
module tb_sdram_wr_fifo_ctrl;

  typedef struct packed {
    logic [23:0] addr;
    logic [9:0]  len;
  } burst_t;

  logic clk_100m = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_100m = ~clk_100m;

  sdram_wr_fifo_ctrl_if bus ();

  sdram_wr_fifo_ctrl #(
    .BURST_LEN (10),
    .ADDR_BASE (24'h000000),
    .ADDR_MAX  (24'h000013)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus_io   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acks_seen = 0;
  int resp_n = 0;
  logic [15:0] exp_data [$];
  burst_t      exp_burst [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic [23:0] a, input logic [9:0] l);
    burst_t b;
    b.addr = a;
    b.len  = l;
    exp_burst.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk_100m);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(negedge clk_100m);
    bus.flush = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_data.size() != 0 || exp_burst.size() != 0 || bus.sdram_wr_req) && n < budget) begin
      @(negedge clk_100m);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_data.size());
    end
    repeat (3) @(negedge clk_100m);
  endtask

  // Monitor: samples 2 ns after the falling edge, away from the active edge.
  initial begin
    logic   prev_req;
    burst_t b;
    logic [15:0] w;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_100m);
      #2;
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (bus.sdram_wr_req && !prev_req) begin
          $display("burst addr=%06h len=%0d", bus.sdram_wr_addr, bus.wr_burst_len);
          if (exp_burst.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %0h len %0d expected no request",
                     bus.sdram_wr_addr, bus.wr_burst_len);
          end else begin
            b = exp_burst.pop_front();
            check("burst_addr", 32'(bus.sdram_wr_addr), 32'(b.addr));
            check("burst_len", 32'(bus.wr_burst_len), 32'(b.len));
          end
        end
        if (bus.sdram_wr_req && bus.sdram_wr_ack) begin
          acks_seen++;
          $display("word %04h", bus.sdram_data_in);
          if (exp_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", bus.sdram_data_in);
          end else begin
            w = exp_data.pop_front();
            check("wr_data", 32'(bus.sdram_data_in), 32'(w));
          end
        end
        if (bus.wr_done) done_cnt++;
        prev_req = bus.sdram_wr_req;
      end
    end
  end

  // SDRAM responder: acks one cycle after req for wr_burst_len cycles.
  initial begin
    bus.sdram_wr_ack = 1'b0;
    forever begin
      @(negedge clk_100m);
      if (rst_n && bus.sdram_wr_req) begin
        resp_n = int'(bus.wr_burst_len);
        @(negedge clk_100m);
        for (int i = 0; i < resp_n; i++) begin
          if (!rst_n) break;
          bus.sdram_wr_ack = 1'b1;
          @(negedge clk_100m);
        end
        bus.sdram_wr_ack = 1'b0;
      end
    end
  end

  initial begin
    bus.init_end   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.flush      = 1'b0;
    repeat (3) @(negedge clk_100m);

    // reset values
    check("rst_req", 32'(bus.sdram_wr_req), 32'd0);
    check("rst_done", 32'(bus.wr_done), 32'd0);
    check("rst_addr", 32'(bus.sdram_wr_addr), 32'h0);
    check("rst_len", 32'(bus.wr_burst_len), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_data", 32'(bus.sdram_data_in), 32'h0);
    rst_n = 1'b1;
    @(negedge clk_100m);

    // 20 bytes 0x00..0x13 -> one full burst at address 0
    bus.init_end = 1'b1;
    done_cnt = 0;
    push_burst(24'h0, 10'd10);
    for (int k = 0; k < 10; k++) exp_data.push_back({8'(2 * k), 8'(2 * k + 1)});
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    wait_drain("t1", 200);
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_next_addr", 32'(bus.sdram_wr_addr), 32'd10);
    check("t1_count", 32'(bus.fifo_count), 32'd0);

    // odd byte + flush -> 2-word burst, pad low byte; 12+9 > 0x13 wraps to 0
    done_cnt = 0;
    push_burst(24'd10, 10'd2);
    exp_data.push_back(16'hAABB);
    exp_data.push_back(16'hCC00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    pulse_flush();
    wait_drain("t2", 100);
    check("t2_done", 32'(done_cnt), 32'd1);
    check("t2_next_addr", 32'(bus.sdram_wr_addr), 32'd0);
    check("t2_count", 32'(bus.fifo_count), 32'd0);

    // continuous bytes while bursts are acked -> two bursts, order preserved
    done_cnt = 0;
    push_burst(24'd0, 10'd10);
    push_burst(24'd10, 10'd10);
    for (int k = 0; k < 20; k++) exp_data.push_back({8'(8'h40 + 2 * k), 8'(8'h41 + 2 * k)});
    for (int i = 0; i < 40; i++) send_byte(8'(8'h40 + i));
    wait_drain("t3", 400);
    check("t3_done", 32'(done_cnt), 32'd2);
    check("t3_next_addr", 32'(bus.sdram_wr_addr), 32'd0);
    check("t3_count", 32'(bus.fifo_count), 32'd0);

    // flush with empty FIFO clears silently: a later single word stays put
    pulse_flush();
    repeat (5) @(negedge clk_100m);
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (10) @(negedge clk_100m);
    check("flush_empty_count", 32'(bus.fifo_count), 32'd1);
    check("flush_empty_req", 32'(bus.sdram_wr_req), 32'd0);

    // init_end low, 130 more bytes -> FIFO saturates at 64, overflow sticky
    bus.init_end = 1'b0;
    for (int i = 0; i < 130; i++) send_byte(8'(i));
    repeat (5) @(negedge clk_100m);
    check("ovf_count", 32'(bus.fifo_count), 32'd64);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_req", 32'(bus.sdram_wr_req), 32'd0);

    // reset clears buffered data
    rst_n = 1'b0;
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
    @(negedge clk_100m);
    check("rst2_count", 32'(bus.fifo_count), 32'd0);
    check("rst2_ovf", 32'(bus.overflow), 32'd0);

    // reset in the middle of a write burst
    bus.init_end = 1'b1;
    acks_seen = 0;
    push_burst(24'd0, 10'd10);
    for (int k = 0; k < 10; k++) exp_data.push_back({8'(8'h80 + 2 * k), 8'(8'h81 + 2 * k)});
    for (int i = 0; i < 20; i++) send_byte(8'(8'h80 + i));
    for (int n = 0; n < 200 && acks_seen < 4; n++) @(negedge clk_100m);
    check("midwr_acks_reached", 32'(acks_seen >= 4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwr_req", 32'(bus.sdram_wr_req), 32'd0);
    check("midwr_done", 32'(bus.wr_done), 32'd0);
    check("midwr_count", 32'(bus.fifo_count), 32'd0);
    check("midwr_addr", 32'(bus.sdram_wr_addr), 32'd0);
    check("midwr_len", 32'(bus.wr_burst_len), 32'd0);
    check("midwr_data", 32'(bus.sdram_data_in), 32'd0);
    exp_data.delete();
    exp_burst.delete();
    repeat (3) @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (15) @(negedge clk_100m);
    check("post_rst_count", 32'(bus.fifo_count), 32'd0);

    // three full bursts with ADDR_MAX 0x13 -> addresses 0, 10, 0
    done_cnt = 0;
    push_burst(24'd0, 10'd10);
    push_burst(24'd10, 10'd10);
    push_burst(24'd0, 10'd10);
    for (int k = 0; k < 30; k++) exp_data.push_back({8'(8'hC0 + 2 * k), 8'(8'hC1 + 2 * k)});
    for (int i = 0; i < 60; i++) send_byte(8'(8'hC0 + i));
    wait_drain("t6", 600);
    check("t6_done", 32'(done_cnt), 32'd3);
    check("t6_next_addr", 32'(bus.sdram_wr_addr), 32'd10);
    check("t6_count", 32'(bus.fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
